prog_counter: RTL

Parametrised, programmable up/down counter. It is the next-generation general counter for the design, used for timers, event counting and frame/line counting. Adds a runtime modulus, direction control, synchronous load/clear, an enable-gated prescaler, wrap-or-saturate mode, a terminal-count pulse and a sticky overflow flag.

---
 rtl/prog_counter_if.sv | 32 +++
 rtl/prog_counter.sv | 96 +++++++++
 2 files changed

// File: rtl/prog_counter_if.sv
// Purpose: control/status bundle for the programmable counter (program inputs, count outputs).
// Latency: pure wiring; no storage.
// Backpressure: none; inputs are sampled every cycle and outputs are always valid.
interface prog_counter_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic                  en;
  logic                  clr;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic                  dir;
  logic [WIDTH-1:0]      max_val;
  logic [PRESCALE_W-1:0] prescale;
  logic                  ovf_clr;
  logic [WIDTH-1:0]      cnt_o;
  logic                  tc_o;
  logic                  ovf_o;
  logic                  zero_o;

  // The block that programs and observes the counter.
  modport master (
    output en, clr, load, load_val, dir, max_val, prescale, ovf_clr,
    input  cnt_o, tc_o, ovf_o, zero_o
  );

  // The counter itself.
  modport slave (
    input  en, clr, load, load_val, dir, max_val, prescale, ovf_clr,
    output cnt_o, tc_o, ovf_o, zero_o
  );
endinterface

// File: rtl/prog_counter.sv
// Purpose: programmable up/down counter with runtime modulus, prescaler, wrap/saturate, tc pulse, sticky ovf.
// Latency: cnt_o/tc_o/ovf_o update one clk after the controlling input; zero_o is combinational from cnt_o.
// Backpressure: none; en gates the prescaler, and clr > load > tick > hold decides each cycle.
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4,
  parameter int SATURATE   = 0
) (
  input logic            clk,
  input logic            reset,
  prog_counter_if.slave  bus
);

  logic [WIDTH-1:0]      cnt_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic                  tc_q;
  logic                  ovf_q;

  logic                  tick;
  logic [WIDTH-1:0]      cnt_nxt;
  logic [PRESCALE_W-1:0] pre_nxt;
  logic                  tc_nxt;
  logic                  ovf_nxt;

  // Prescaler: ">=" rather than "==" so that lowering prescale mid-run ticks on the next enabled cycle.
  always_comb begin
    tick    = 1'b0;
    pre_nxt = pre_q;
    if (bus.clr || bus.load) begin
      pre_nxt = '0;
    end else if (bus.en) begin
      if (pre_q >= bus.prescale) begin
        tick    = 1'b1;
        pre_nxt = '0;
      end else begin
        pre_nxt = pre_q + 1'b1;
      end
    end
  end

  // Count/limit next state. A limit tick always raises tc and ovf; ovf set beats ovf_clr.
  always_comb begin
    cnt_nxt = cnt_q;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf_q & ~bus.ovf_clr;
    if (bus.clr) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (bus.load) begin
      // Out-of-range load values are kept; the limit rules pull them back on the next tick.
      cnt_nxt = bus.load_val;
    end else if (tick) begin
      if (bus.dir) begin
        if (cnt_q < bus.max_val) begin
          cnt_nxt = cnt_q + 1'b1;
        end else begin
          cnt_nxt = (SATURATE != 0) ? bus.max_val : '0;
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end
      end else begin
        if (cnt_q > bus.max_val) begin
          // Recovery from an out-of-range load or a lowered max_val: clamp, no terminal count.
          cnt_nxt = bus.max_val;
        end else if (cnt_q != '0) begin
          cnt_nxt = cnt_q - 1'b1;
        end else begin
          cnt_nxt = (SATURATE != 0) ? '0 : bus.max_val;
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pre_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      pre_q <= pre_nxt;
      tc_q  <= tc_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  assign bus.cnt_o  = cnt_q;
  assign bus.tc_o   = tc_q;
  assign bus.ovf_o  = ovf_q;
  assign bus.zero_o = (cnt_q == '0);

endmodule
